mdu_hilo: RTL and testbench

Parametrised multi-cycle multiply/divide unit holding the HI/LO registers. Sits in the E stage beside the ALU and is driven by the decoder's `E_opHILO` code and the forwarded rs/rt operands. Models the iterative latency of mult/div with a `busy` output, which the D-stage stall logic uses to hold any mult/div/mf/mt instruction while an operation is in flight.

---
 rtl/mdu_hilo_pkg.sv | 43 ++++
 rtl/mdu_core.sv | 62 ++++++
 rtl/mdu_hilo.sv | 118 +++++++++++
 tb/tb_mdu_hilo.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared HILO op encoding and classification helpers, used by the decoder, stall unit and MDU.
// Build option: define MDU_MADD_EN to enable the madd/maddu/msub/msubu class.
package mdu_hilo_pkg;

    typedef enum logic [3:0] {
        HILO_NONE  = 4'd0,
        HILO_MULT  = 4'd1,
        HILO_MULTU = 4'd2,
        HILO_DIV   = 4'd3,
        HILO_DIVU  = 4'd4,
        HILO_MFHI  = 4'd5,
        HILO_MFLO  = 4'd6,
        HILO_MTHI  = 4'd7,
        HILO_MTLO  = 4'd8,
        HILO_MADD  = 4'd9,
        HILO_MADDU = 4'd10,
        HILO_MSUB  = 4'd11,
        HILO_MSUBU = 4'd12
    } hilo_op_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    function automatic logic is_md(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == HILO_MULT) || (op == HILO_MULTU) || is_div(op) ||
               (op == HILO_MADD) || (op == HILO_MADDU) ||
               (op == HILO_MSUB) || (op == HILO_MSUBU);
`else
        return (op == HILO_MULT) || (op == HILO_MULTU) || is_div(op);
`endif
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == HILO_MTHI) || (op == HILO_MTLO);
    endfunction

    function automatic logic is_mf(input logic [3:0] op);
        return (op == HILO_MFHI) || (op == HILO_MFLO);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath: produces the {HI,LO} result for the latched op.
// Build option: MDU_MADD_EN adds the accumulate/subtract path.
module mdu_core
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MDU_MADD_EN
    input  logic [2*WIDTH-1:0] acc,
`endif
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   dvs_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide runs on magnitudes; MIN/-1 falls out as LO=MIN, HI=0 without a special case.
    assign a_neg    = (op == HILO_DIV) && a[WIDTH-1];
    assign b_neg    = (op == HILO_DIV) && b[WIDTH-1];
    assign dvd      = a_neg ? -a : a;
    assign dvs      = b_neg ? -b : b;
    assign div_zero = is_div(op) && (b == '0);
    assign dvs_safe = (dvs == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem      = a_neg ? -r_mag : r_mag;

    always_comb begin
        result = '0;
        case (op)
            HILO_MULT:  result = prod_s;
            HILO_MULTU: result = prod_u;
            HILO_DIV,
            HILO_DIVU:  result = {rem, quo};
`ifdef MDU_MADD_EN
            HILO_MADD:  result = acc + prod_s;
            HILO_MADDU: result = acc + prod_u;
            HILO_MSUB:  result = acc - prod_s;
            HILO_MSUBU: result = acc - prod_u;
`endif
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO, the latency counter and the busy handshake.
// Build option: MDU_MADD_EN enables ops 9-12 (madd/maddu/msub/msubu).
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e             state;
    state_e             next_state;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               accept;
    logic               commit;
    logic               hi_we;
    logic               lo_we;
    logic [2*WIDTH-1:0] core_result;
    logic               core_div_zero;

    mdu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
`ifdef MDU_MADD_EN
        .acc     ({hi, lo}),
`endif
        .result  (core_result),
        .div_zero(core_div_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (cnt == CW'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Any start seen while an operation is in flight is dropped, including mthi/mtlo.
    always_comb begin
        accept = (state == IDLE) && start && is_md(op);
        commit = (state == RUN) && (cnt == CW'(1));
        hi_we  = (state == IDLE) && start && (op == HILO_MTHI);
        lo_we  = (state == IDLE) && start && (op == HILO_MTLO);
        busy   = (start && is_md(op)) || (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= HILO_NONE;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            cnt  <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            op_q <= op;
            a_q  <= rs_data;
            b_q  <= rt_data;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!core_div_zero) begin
                {hi, lo} <= core_result;
            end
        end else begin
            if (hi_we) hi <= rs_data;
            if (lo_we) lo <= rs_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (start && op == HILO_MFHI) rd_data = hi;
        else if (start && op == HILO_MFLO) rd_data = lo;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: cycle-level behavioural model plus literal pins.
// Works with or without MDU_MADD_EN defined.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   op;
    logic         start;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    bit           pend;
    int           pend_accept;
    int           pend_commit;
    logic [64:0]  pend_res;
    int           cycle = 0;

    mdu_hilo #(
        .WIDTH(W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (op),
        .start  (start),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .rd_data(rd_data),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    function automatic bit modelMd(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
`else
        return (o >= 4'd1 && o <= 4'd4);
`endif
    endfunction

    // Returns {write_enable, new HI, new LO} from plain integer arithmetic.
    function automatic logic [64:0] modelResult(input logic [3:0] o, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] h,
                                                input logic [31:0] l);
        longint sa, sb, q, rm;
        longint unsigned ua, ub;
        logic [63:0] acc, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        acc = {h, l};
        r   = acc;
        case (o)
            4'd1: r = sa * sb;
            4'd2: r = ua * ub;
            4'd3: begin
                if (b == 32'd0) return {1'b0, acc};
                q  = sa / sb;
                rm = sa % sb;
                r  = {rm[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {1'b0, acc};
                r = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd9:  r = acc + 64'(sa * sb);
            4'd10: r = acc + 64'(ua * ub);
            4'd11: r = acc - 64'(sa * sb);
            4'd12: r = acc - 64'(ua * ub);
            default: r = acc;
        endcase
        return {1'b1, r};
    endfunction

    function automatic bit inFlight();
        return pend && (cycle > pend_accept) && (cycle <= pend_commit);
    endfunction

    task automatic resetModel();
        m_hi = '0;
        m_lo = '0;
        pend = 1'b0;
    endtask

    task automatic modelEdge(input logic [3:0] o, input logic s, input logic [31:0] a,
                             input logic [31:0] b);
        if (rst_n) begin
            if (inFlight()) begin
                if (cycle == pend_commit) begin
                    if (pend_res[64]) {m_hi, m_lo} = pend_res[63:0];
                    pend = 1'b0;
                end
            end else if (s) begin
                if (modelMd(o)) begin
                    pend        = 1'b1;
                    pend_accept = cycle;
                    pend_commit = cycle + ((o == 4'd3 || o == 4'd4) ? DC : MC);
                    pend_res    = modelResult(o, a, b, m_hi, m_lo);
                end else if (o == 4'd7) begin
                    m_hi = a;
                end else if (o == 4'd8) begin
                    m_lo = a;
                end
            end
        end
        cycle++;
    endtask

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic         exp_busy;
        logic [W-1:0] exp_rd;
        exp_busy = rst_n && (inFlight() || (start && modelMd(op)));
        exp_rd   = (start && op == 4'd5) ? m_hi : (start && op == 4'd6) ? m_lo : '0;
        checkLit("busy", {31'b0, busy}, {31'b0, exp_busy});
        checkLit("rd_data", rd_data, exp_rd);
        checkLit("hi", hi, m_hi);
        checkLit("lo", lo, m_lo);
    endtask

    always @(negedge clk) if (check_en) checkOutput();

    // One clock cycle with the given inputs; inputs return to idle afterwards.
    task automatic applyStimulus(input logic [3:0] o, input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
        op      = o;
        start   = s;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        modelEdge(o, s, a, b);
        op      = 4'd0;
        start   = 1'b0;
        rs_data = '0;
        rt_data = '0;
        #1;
    endtask

    task automatic waitIdle(input string name, input int expected);
        int n;
        n = 0;
        while (busy && n < 60) begin
            applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: busy never dropped (timeout)", name);
        end
        checkLit(name, 32'(n), 32'(expected));
    endtask

    task automatic peekRd(input string name, input logic [3:0] o, input logic [31:0] exp);
        op    = o;
        start = 1'b1;
        #1;
        checkLit(name, rd_data, exp);
        applyStimulus(o, 1'b1, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n   = 1'b0;
        op      = 4'd0;
        start   = 1'b0;
        rs_data = '0;
        rt_data = '0;
        resetModel();
        #2;
        check_en = 1'b1;
        repeat (2) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;

        peekRd("reset_mfhi", 4'd5, 32'h0);
        peekRd("reset_mflo", 4'd6, 32'h0);
        checkLit("reset_busy", {31'b0, busy}, 32'd0);

        // mult -3 x 7
        applyStimulus(4'd1, 1'b1, 32'hFFFFFFFD, 32'd7);
        waitIdle("mult_busy_len", MC);
        checkLit("mult_hi", hi, 32'hFFFFFFFF);
        checkLit("mult_lo", lo, 32'hFFFFFFEB);
        checkLit("model_mult_lo", m_lo, 32'hFFFFFFEB);

        applyStimulus(4'd2, 1'b1, 32'hFFFFFFFF, 32'd2);
        waitIdle("multu_busy_len", MC);
        checkLit("multu_hi", hi, 32'h1);
        checkLit("multu_lo", lo, 32'hFFFFFFFE);

        applyStimulus(4'd3, 1'b1, 32'hFFFFFFF9, 32'd2);
        waitIdle("div_busy_len", DC);
        checkLit("div_lo", lo, 32'hFFFFFFFD);
        checkLit("div_hi", hi, 32'hFFFFFFFF);
        checkLit("model_div_hi", m_hi, 32'hFFFFFFFF);

        applyStimulus(4'd4, 1'b1, 32'd7, 32'd0);
        waitIdle("divz_busy_len", DC);
        checkLit("divz_lo", lo, 32'hFFFFFFFD);
        checkLit("divz_hi", hi, 32'hFFFFFFFF);

        applyStimulus(4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        waitIdle("ovf_busy_len", DC);
        checkLit("ovf_lo", lo, 32'h80000000);
        checkLit("ovf_hi", hi, 32'h0);

        applyStimulus(4'd4, 1'b1, 32'd100, 32'd7);
        waitIdle("divu_busy_len", DC);
        checkLit("divu_lo", lo, 32'd14);
        checkLit("divu_hi", hi, 32'd2);

        // mthi then mfhi next cycle
        applyStimulus(4'd7, 1'b1, 32'h1234, 32'd0);
        peekRd("mthi_mfhi", 4'd5, 32'h1234);

        // mtlo during busy is ignored
        applyStimulus(4'd1, 1'b1, 32'd2, 32'd3);
        applyStimulus(4'd8, 1'b1, 32'hDEAD, 32'd0);
        peekRd("mfhi_busy", 4'd5, 32'h1234);
        waitIdle("mtlo_busy_len", MC - 2);
        checkLit("mtlo_ignored_lo", lo, 32'd6);

        // back-to-back: div accepted in cycle N+1
        applyStimulus(4'd2, 1'b1, 32'd5, 32'd5);
        repeat (MC) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        checkLit("b2b_first_lo", lo, 32'd25);
        applyStimulus(4'd4, 1'b1, 32'd100, 32'd9);
        waitIdle("b2b_second_len", DC);
        checkLit("b2b_lo", lo, 32'd11);
        checkLit("b2b_hi", hi, 32'd1);

        // start at cycle 3 of a multiply is dropped
        applyStimulus(4'd1, 1'b1, 32'd6, 32'd7);
        applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        applyStimulus(4'd4, 1'b1, 32'd9, 32'd3);
        waitIdle("ignored_start_len", MC - 3);
        checkLit("ignored_lo", lo, 32'd42);
        checkLit("ignored_hi", hi, 32'd0);
        repeat (3) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        checkLit("ignored_no_late_div", lo, 32'd42);

`ifdef MDU_MADD_EN
        applyStimulus(4'd7, 1'b1, 32'h0, 32'd0);
        applyStimulus(4'd8, 1'b1, 32'hFFFFFFFF, 32'd0);
        applyStimulus(4'd10, 1'b1, 32'd1, 32'd1);
        waitIdle("maddu_len", MC);
        checkLit("maddu_hi", hi, 32'd1);
        checkLit("maddu_lo", lo, 32'd0);
        applyStimulus(4'd11, 1'b1, 32'd1, 32'd1);
        waitIdle("msub_len", MC);
        checkLit("msub_hi", hi, 32'd0);
        checkLit("msub_lo", lo, 32'hFFFFFFFF);
`else
        op    = 4'd9;
        start = 1'b1;
        rs_data = 32'd1;
        rt_data = 32'd1;
        #1;
        checkLit("madd_off_busy", {31'b0, busy}, 32'd0);
        applyStimulus(4'd9, 1'b1, 32'd1, 32'd1);
        checkLit("madd_off_busy_after", {31'b0, busy}, 32'd0);
        checkLit("madd_off_lo", lo, 32'd42);
        checkLit("madd_off_hi", hi, 32'd0);
`endif

        // reset in the middle of a divide
        applyStimulus(4'd3, 1'b1, 32'd50, 32'd3);
        repeat (3) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkLit("rst_mid_busy", {31'b0, busy}, 32'd0);
        checkLit("rst_mid_hi", hi, 32'd0);
        checkLit("rst_mid_lo", lo, 32'd0);
        repeat (2) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        repeat (DC + 2) applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
        checkLit("rst_no_late_commit_lo", lo, 32'd0);
        checkLit("rst_no_late_busy", {31'b0, busy}, 32'd0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
